// File: rtl/bin_to_bcd_seq_pkg.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the iterative binary-to-BCD converter:
//   - FSM state encoding
//   - BCD nibble width
//   - bcd_max_value(): largest decimal value representable in N BCD digits
// ----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BCD_NIBBLE = 4;

    // 10^digits - 1, evaluated at elaboration time.
    function automatic logic [63:0] bcd_max_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction for one BCD nibble: values >= 5
// get +3 (4-bit wrap, no carry out) so the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   nib_i  4-bit BCD nibble before correction
//   nib_o  4-bit corrected nibble
// ----------------------------------------------------------------------------
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_NIBBLE-1:0] nib_i,
    output logic [BCD_NIBBLE-1:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative shift-add-3 (double-dabble) binary-to-BCD converter feeding the
// per-digit 7-segment decoders. One bit is processed per clock; a conversion
// takes BIN_WIDTH+2 cycles from accept to the next accept.
//
// Optional feature macro: BIN_TO_BCD_SEQ_BLANK_EN
//   defined   -> out_blank carries the leading-zero blank mask
//   undefined -> out_blank is tied to zero, no blanking logic
//
// State table:
//   IDLE  | ready for a new value; in_ready=1
//   SHIFT | one add-3/shift step per cycle, BIN_WIDTH steps
//   DONE  | publish result, pulse out_valid, return to IDLE
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   in_valid      in_bin valid this cycle
//   in_ready      converter accepts a value (IDLE only)
//   in_bin        unsigned binary input
//   out_valid     one-cycle pulse when outputs update
//   out_bcd       packed BCD, digit 0 in [3:0]
//   out_overflow  last conversion saturated to all nines
//   out_blank     leading-zero blank mask (digit 0 never blanked)
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_WIDTH-1:0]         in_bin,
    output logic                         out_valid,
    output logic [BCD_NIBBLE*DIGITS-1:0] out_bcd,
    output logic                         out_overflow,
    output logic [DIGITS-1:0]            out_blank
);

    localparam int BCD_W = BCD_NIBBLE * DIGITS;
    localparam int SCR_W = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int CMP_W = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;

    localparam logic [CMP_W-1:0] MAX_VAL  = CMP_W'(bcd_max_value(DIGITS));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    state_e             state_q, state_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]   bcd_field;
    logic [BCD_W-1:0]   bcd_corr;
    logic [SCR_W-1:0]   shifted;
    logic [BCD_W-1:0]   result;

    assign bcd_field = scratch_q[SCR_W-1 -: BCD_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_field[BCD_NIBBLE*g +: BCD_NIBBLE]),
            .nib_o (bcd_corr[BCD_NIBBLE*g +: BCD_NIBBLE])
        );
    end

    // Correct every nibble first, then shift the whole scratch left by one.
    assign shifted = {bcd_corr, scratch_q[BIN_WIDTH-1:0]} << 1;
    assign result  = ovf_q ? {DIGITS{4'h9}} : bcd_field;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)          state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE:                         state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == ST_IDLE);
    end

    // Datapath next values
    always_comb begin
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_bcd_d   = out_bcd_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    scratch_d = {{BCD_W{1'b0}}, in_bin};
                    cnt_d     = '0;
                    ovf_d     = (CMP_W'(in_bin) > MAX_VAL);
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                out_bcd_d   = result;
                out_ovf_d   = ovf_q;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_bcd      = out_bcd_q;
    assign out_overflow = out_ovf_q;

`ifdef BIN_TO_BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              upper_zero;

    // Walk down from the top digit; a digit blanks only while every digit
    // above it (and itself) is zero. Saturated results are all nines, and
    // overflow is gated anyway so it never blanks.
    always_comb begin
        blank_d    = '0;
        upper_zero = !ovf_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (result[BCD_NIBBLE*i +: BCD_NIBBLE] == 4'd0);
            blank_d[i] = upper_zero;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else if (state_q == ST_DONE) begin
            blank_q <= blank_d;
        end
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed bench for bin_to_bcd_seq (BIN_WIDTH=14, DIGITS=4). Expected
// results come from a decimal model and are queued at each accept; the
// monitor pops and compares on every out_valid pulse.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int W = 14;
    localparam int D = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
        int          acc;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_bin;
    logic          out_valid;
    logic [15:0]   out_bcd;
    logic          out_overflow;
    logic [D-1:0]  out_blank;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    bin_to_bcd_seq #(.BIN_WIDTH(W), .DIGITS(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bin       (in_bin),
        .out_valid    (out_valid),
        .out_bcd      (out_bcd),
        .out_overflow (out_overflow),
        .out_blank    (out_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        int   t;
        int   p;
        e.acc   = acc;
        e.ovf   = (v > 9999);
        e.bcd   = '0;
        e.blank = '0;
        if (e.ovf) begin
            e.bcd = 16'h9999;
        end else begin
            t = v;
            for (int i = 0; i < D; i++) begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
        p = 1;
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            e.blank[i] = !e.ovf && ((v / p) == 0);
        end
`else
        p = 0;
`endif
        return e;
    endfunction

    // Monitor: scoreboard pushes, out_valid checks, in_ready and hold checks.
    logic [15:0] last_bcd   = '0;
    logic        last_ovf   = 1'b0;
    logic [3:0]  last_blank = '0;

    always @(negedge clk) begin
        logic busy;
        exp_t e;
        if (!reset_n) begin
            last_bcd   = '0;
            last_ovf   = 1'b0;
            last_blank = '0;
        end else begin
            busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc <= sb[0].acc + W);
            check("in_ready", 32'(in_ready), 32'(!busy));
            if (out_valid) begin
                check("unexpected_out_valid", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("latency",      32'(cyc - e.acc), 32'(W + 1));
                    check("out_bcd",      32'(out_bcd),      32'(e.bcd));
                    check("out_overflow", 32'(out_overflow), 32'(e.ovf));
                    check("out_blank",    32'(out_blank),    32'(e.blank));
                end
                last_bcd   = out_bcd;
                last_ovf   = out_overflow;
                last_blank = out_blank;
            end else begin
                check("hold_bcd",   32'(out_bcd),      32'(last_bcd));
                check("hold_ovf",   32'(out_overflow), 32'(last_ovf));
                check("hold_blank", 32'(out_blank),    32'(last_blank));
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(int'(in_bin), cyc + 1));
            end
        end
    end

    task automatic send(input int v);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("send_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = W'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    int acc_edge[3];

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_out_bcd",   32'(out_bcd),      32'd0);
        check("rst_out_ovf",   32'(out_overflow), 32'd0);
        check("rst_out_blank", 32'(out_blank),    32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1234 with in_bin disturbed mid-conversion
        send(1234);
        in_bin = W'(5555);
        repeat (3) @(posedge clk);
        #1;
        in_bin = W'(16383);
        drain();

        // boundaries and overflow
        send(0);     drain();
        send(9999);  drain();
        send(12345); drain();
        send(16383); drain();
        send(42);    drain();
        send(0);     drain();

        // back-to-back with in_valid held high
        in_valid = 1'b1;
        in_bin   = W'(7);
        for (int j = 0; j < 3; j++) begin
            int k;
            k = 0;
            while (!in_ready && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            check("held_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            acc_edge[j] = cyc;
            in_bin = W'(8 + j);
        end
        in_valid = 1'b0;
        check("accept_spacing_1", 32'(acc_edge[1] - acc_edge[0]), 32'(W + 2));
        check("accept_spacing_2", 32'(acc_edge[2] - acc_edge[1]), 32'(W + 2));
        drain();

        // reset 5 cycles into SHIFT
        send(4321);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid),    32'd0);
        check("abort_out_bcd",   32'(out_bcd),      32'd0);
        check("abort_out_ovf",   32'(out_overflow), 32'd0);
        check("abort_out_blank", 32'(out_blank),    32'd0);
        check("abort_in_ready",  32'(in_ready),     32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(56);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the per-digit 7-segment decoders on the Alchitry IO board.
- Turns a binary count or measurement into DIGITS packed BCD nibbles, so the display array shows decimal rather than hex.
- Multi-cycle, with a valid/ready handshake on input and a one-cycle valid pulse on output.

Parameters:
- BIN_WIDTH, 14, width of binary input; legal range 1..32.
- DIGITS, 4, number of BCD output digits; legal range 1..8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bin is valid this cycle.
- in_ready  output  1  block can accept a new value (high only in IDLE).
- in_bin  input  BIN_WIDTH  unsigned binary value.
- out_valid  output  1  one-cycle pulse: out_bcd/out_overflow updated.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0], digit DIGITS-1 in MSBs.
- out_overflow  output  1  last conversion saturated.
- out_blank  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - in_ready=1 on the first cycle after release.
  - out_valid=0, out_bcd=0, out_overflow=0, out_blank=0.
  - Shift register and bit counter cleared.
- Registers:
  - scratch: {BCD field 4*DIGITS bits, binary field BIN_WIDTH bits}.
  - bit counter: clog2(BIN_WIDTH+1) bits.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On edge k with in_valid&&in_ready: load binary field=in_bin, BCD field=0, counter=0.
  - Latch ovf = (in_bin > 10^DIGITS-1), comparing at max(BIN_WIDTH,32) bits.
  - Go to SHIFT.
  - If in_valid is low, stay in IDLE.
- SHIFT:
  - in_ready=0.
  - Each edge: every BCD nibble >=5 gets +3 (4-bit, no carry out), then the whole scratch shifts left 1.
  - Counter increments.
  - After BIN_WIDTH shifts (edge k+BIN_WIDTH), go to DONE.
- DONE:
  - in_ready=0.
  - Next edge (k+BIN_WIDTH+1): out_bcd <= ovf ? all nibbles 4'h9 : BCD field.
  - Same edge: out_overflow<=ovf, out_valid<=1, go to IDLE.
- out_valid:
  - High for exactly one cycle, BIN_WIDTH+1 cycles after the accept edge.
  - in_ready is already 1 in that same cycle.
- Throughput: one conversion per BIN_WIDTH+2 cycles with in_valid held high; no inputs dropped, none double-accepted.
- Hold: out_bcd, out_overflow and out_blank hold their value between conversions; only out_valid pulses.
- in_bin changes while in_ready=0 are ignored; the value is sampled only at the accept edge.
- Boundaries:
  - in_bin=0 gives all-zero out_bcd.
  - in_bin=10^DIGITS-1 is not overflow.
  - If BIN_WIDTH cannot reach 10^DIGITS, out_overflow is constant 0.
- Reset mid-SHIFT/DONE: immediate return to IDLE with reset values; no out_valid pulse for the aborted conversion.

Optional Feature:
- Macro: BIN_TO_BCD_SEQ_BLANK_EN.
- Defined:
  - out_blank[i]=1 when digit i and all higher digits are zero; digit 0 is never blanked.
  - Updated on the same edge as out_bcd.
  - Overflow results blank nothing.
- Undefined: out_blank is tied to 0 and no blanking logic is synthesised; the port still exists.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - BCD_NIBBLE=4.
  - The constant function computing 10^DIGITS-1.
- Sub-module bcd_add3: combinational per-nibble "if >=5 add 3" correction, instantiated DIGITS times via generate.

Test Plan:
- in_bin=1234, in_valid pulsed for 1 cycle -> out_valid exactly 15 cycles after accept edge; out_bcd=16'h1234, out_overflow=0.
- in_bin=0, then in_bin=9999 -> out_bcd=16'h0000, then 16'h9999; out_overflow=0 both times.
- in_bin=12345 (and 16383) -> out_bcd=16'h9999, out_overflow=1.
- in_valid held high, in_bin stepping 7,8,9 on each accept -> accepts exactly 16 cycles apart; outputs 16'h0007, 16'h0008, 16'h0009 in order; in_ready=0 during SHIFT/DONE.
- reset_n pulled low 5 cycles into SHIFT for in_bin=4321 -> all outputs 0 asynchronously; no out_valid pulse; next conversion of 56 gives 16'h0056.
- With BIN_TO_BCD_SEQ_BLANK_EN, in_bin=42 -> out_bcd=16'h0042, out_blank=4'b1100.
  - in_bin=0 gives out_blank=4'b1110.
  - Without the macro, out_blank=0 in both cases.
